// File: rtl/pcm_tx_pkg.sv
// Shared types and defaults for the PCM serial transmitter.
// Optional even-parity bit is enabled by defining PCM_TX_PARITY_EN.
package pcm_tx_pkg;

   typedef enum logic {ST_IDLE, ST_SHIFT} pcm_state_e;

   localparam int unsigned DefDataW  = 16;
   localparam int unsigned DefDepth  = 8;
   localparam int unsigned DefClkDiv = 4;

   // Callers zero-extend; leading zeros do not change even parity.
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/pcm_tx_fifo.sv
// Synchronous single-clock FIFO; DEPTH must be a power of two so pointers wrap naturally.
module pcm_tx_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full  = (count_q == (PtrW + 1)'(DEPTH));
   assign empty = (count_q == '0);
   assign level = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + PtrW'(do_push);
      rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; emptiness is tracked by count_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pcm_serial_tx.sv
// MSB-first serial transmitter with bit clock and frame sync, fed from a small FIFO.
// Defining PCM_TX_PARITY_EN appends an even-parity bit after the LSB.
module pcm_serial_tx
   import pcm_tx_pkg::*;
#(
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned DEPTH   = DefDepth,
   parameter int unsigned CLK_DIV = DefClkDiv
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        y_in,
   input  logic                     y_valid,
   output logic                     y_ready,
   output logic                     sclk_o,
   output logic                     sdata_o,
   output logic                     fsync_o,
   output logic                     busy,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_level
);

`ifdef PCM_TX_PARITY_EN
   localparam int unsigned NBits = DATA_W + 1;
`else
   localparam int unsigned NBits = DATA_W;
`endif
   localparam int unsigned BitW = $clog2(NBits);
   localparam int unsigned DivW = $clog2(CLK_DIV);

   pcm_state_e        state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              sclk_q, sclk_d, sdata_q, sdata_d, fsync_q, fsync_d;
   logic              busy_q, busy_d, overflow_q, overflow_d;
   logic              fifo_full, fifo_empty, pop, load, shifting;
   logic [DATA_W-1:0] fifo_rdata;
`ifdef PCM_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   pcm_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (y_valid & y_ready),
      .wdata (y_in),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Uses the pre-pop count, so a full FIFO refuses even when popping this cycle.
   assign y_ready  = ~fifo_full;
   assign sclk_o   = sclk_q;
   assign sdata_o  = sdata_q;
   assign fsync_o  = fsync_q;
   assign busy     = busy_q;
   assign overflow = overflow_q;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      load       = 1'b0;
      overflow_d = overflow_q | (y_valid & ~y_ready);
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         ST_SHIFT: begin
            if (div_q == DivW'(CLK_DIV - 1)) begin
               div_d = '0;
               if (bit_q == BitW'(NBits - 1)) begin
                  if (!fifo_empty) load = 1'b1;
                  else state_d = ST_IDLE;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      pop = load;
      if (load) begin
         state_d = ST_SHIFT;
         shreg_d = fifo_rdata;
         div_d   = '0;
         bit_d   = '0;
      end
      // Outputs are derived from next-state so the registered pins line up with the counters.
      shifting = (state_d == ST_SHIFT);
      busy_d   = shifting;
      fsync_d  = shifting && (bit_d == '0);
      sclk_d   = shifting && (div_d >= DivW'(CLK_DIV / 2));
      sdata_d  = shifting && shreg_d[DATA_W-1];
`ifdef PCM_TX_PARITY_EN
      par_d = par_q;
      if (load) par_d = even_parity(32'(fifo_rdata));
      if (bit_d == BitW'(DATA_W)) sdata_d = shifting && par_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         sclk_q     <= 1'b0;
         sdata_q    <= 1'b0;
         fsync_q    <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
`ifdef PCM_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         sclk_q     <= sclk_d;
         sdata_q    <= sdata_d;
         fsync_q    <= fsync_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
`ifdef PCM_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_pcm_serial_tx.sv
// Self-checking bench for pcm_serial_tx: direct output checks plus a deserializing scoreboard.
module tb_pcm_serial_tx;

   localparam int DW = 16;
   localparam int DEPTH = 8;
   localparam int CLK_DIV = 4;
`ifdef PCM_TX_PARITY_EN
   localparam int NB = DW + 1;
`else
   localparam int NB = DW;
`endif
   localparam int F = NB * CLK_DIV;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] y_in;
   logic          y_valid;
   logic          y_ready, sclk_o, sdata_o, fsync_o, busy, overflow;
   logic [3:0]    fifo_level;

   int n_chk = 0;
   int n_fail = 0;
   int frames_done = 0;
   logic [DW-1:0] exp_q[$];

   pcm_serial_tx dut (
      .clk        (clk),
      .rst        (rst),
      .y_in       (y_in),
      .y_valid    (y_valid),
      .y_ready    (y_ready),
      .sclk_o     (sclk_o),
      .sdata_o    (sdata_o),
      .fsync_o    (fsync_o),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_bit(input logic [DW-1:0] w, input int i);
      if (i < DW) return w[DW-1-i];
      return ^w;
   endfunction

   function automatic logic [31:0] exp_frame(input logic [DW-1:0] w);
      logic [31:0] r = '0;
      for (int i = 0; i < NB; i++) r = {r[30:0], exp_bit(w, i)};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy !== 1'b0 || fifo_level !== 4'd0) && n < budget) begin
         tick();
         n++;
      end
      check("idle_reached", 32'(n < budget), 1);
   endtask

   // Deserializer: frame starts on fsync rise, bits captured on sclk rise.
   logic          prev_fsync = 1'b0, prev_sclk = 1'b0, in_frame = 1'b0;
   int            mon_bits = 0;
   logic [31:0]   mon_sh = '0;
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         in_frame = 1'b0;
      end else begin
         if (fsync_o === 1'b1 && prev_fsync !== 1'b1) begin
            in_frame = 1'b1;
            mon_bits = 0;
            mon_sh = '0;
         end
         if (in_frame && sclk_o === 1'b1 && prev_sclk !== 1'b1) begin
            mon_sh = {mon_sh[30:0], sdata_o};
            mon_bits++;
            if (mon_bits == NB) begin
               in_frame = 1'b0;
               frames_done++;
               check("frame_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) check("frame_data", mon_sh, exp_frame(exp_q.pop_front()));
            end
         end
      end
      prev_fsync = fsync_o;
      prev_sclk = sclk_o;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int nrise;
      int snap;
      logic [DW-1:0] w;
      logic prev;
      rst = 1'b1;
      y_valid = 1'b0;
      y_in = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_outs", {y_ready, sclk_o, sdata_o, fsync_o, busy, overflow}, 6'b100000);
      check("reset_level", fifo_level, 0);

      // Single word: bit-accurate output trace.
      w = 16'hA5C3;
      exp_q.push_back(w);
      y_in = w;
      y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      check("t1_pre_pop", {busy, fsync_o, 28'(fifo_level)}, {2'b00, 28'd1});
      nrise = 0;
      prev = 1'b0;
      for (int c = 0; c < F; c++) begin
         tick();
         check("t1_outs", {busy, fsync_o, sclk_o, sdata_o},
               {1'b1, c < CLK_DIV, (c % CLK_DIV) >= CLK_DIV / 2, exp_bit(w, c / CLK_DIV)});
         if (sclk_o && !prev) nrise++;
         prev = sclk_o;
      end
      tick();
      check("t1_idle_outs", {busy, fsync_o, sclk_o, sdata_o}, 0);
      check("t1_sclk_rises", nrise, NB);
      wait_idle(50);

      // Back-to-back frames with no gap.
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h8000);
      y_in = 16'h0001;
      y_valid = 1'b1;
      tick();
      y_in = 16'h8000;
      tick();
      y_valid = 1'b0;
      check("t2_first_fsync", fsync_o, 1);
      repeat ((DW - 1) * CLK_DIV) tick();
      check("t2_lsb", {fsync_o, sdata_o}, 2'b01);
      repeat (F - (DW - 1) * CLK_DIV - 1) tick();
      check("t2_last_cycle", {busy, fsync_o}, 2'b10);
      tick();
      check("t2_second_fsync", {busy, fsync_o, sdata_o}, 3'b111);
      wait_idle(300);

      // Burst of DEPTH+2 words, one per cycle.
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (i <= DEPTH) exp_q.push_back(16'h1000 + 16'(i));
         y_in = 16'h1000 + 16'(i);
         y_valid = 1'b1;
         tick();
         if (i == 1) check("t3_popped_w0", {busy, fsync_o, 28'(fifo_level)}, {2'b11, 28'd1});
         if (i == DEPTH) check("t3_full", {y_ready, overflow, 30'(fifo_level)}, {2'b00, 30'(DEPTH)});
      end
      y_valid = 1'b0;
      check("t3_overflow", {overflow, 31'(fifo_level)}, {1'b1, 31'(DEPTH)});
      wait_idle(DEPTH * F * 2 + 200);
      check("t3_overflow_sticky", overflow, 1);

      // Reset during bit 5 of 0xFFFF with three words queued.
      y_in = 16'hFFFF;
      y_valid = 1'b1;
      tick();
      for (int i = 1; i <= 3; i++) begin
         y_in = 16'(i) * 16'h1111;
         tick();
      end
      y_valid = 1'b0;
      check("t4_queued", fifo_level, 3);
      repeat (19) tick();
      check("t4_in_bit5", {busy, fsync_o, sdata_o}, 3'b101);
      rst = 1'b1;
      tick();
      check("t4_rst_outs", {y_ready, sclk_o, sdata_o, fsync_o, busy, overflow}, 6'b100000);
      check("t4_rst_level", fifo_level, 0);
      tick();
      rst = 1'b0;
      snap = frames_done;
      repeat (150) tick();
      check("t4_no_frames", frames_done, snap);
      check("t4_still_idle", {busy, 31'(fifo_level)}, 0);

`ifdef PCM_TX_PARITY_EN
      // Parity bit: 0x0007 -> 1, 0x0003 -> 0; checked by the scoreboard and directly.
      exp_q.push_back(16'h0007);
      y_in = 16'h0007;
      y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      tick();
      repeat (DW * CLK_DIV) tick();
      check("t5_par_odd", {busy, sdata_o}, 2'b11);
      wait_idle(200);
      exp_q.push_back(16'h0003);
      y_in = 16'h0003;
      y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      tick();
      repeat (DW * CLK_DIV) tick();
      check("t5_par_even", {busy, sdata_o}, 2'b10);
      repeat (CLK_DIV - 1) tick();
      check("t5_last_cycle", busy, 1);
      tick();
      check("t5_frame_len", busy, 0);
      wait_idle(50);
`endif

      // Push while full, coinciding with a frame-boundary pop.
      for (int i = 0; i <= DEPTH; i++) begin
         exp_q.push_back(16'h2000 + 16'(i));
         y_in = 16'h2000 + 16'(i);
         y_valid = 1'b1;
         tick();
      end
      y_valid = 1'b0;
      check("t6_full", {y_ready, overflow, 30'(fifo_level)}, {2'b00, 30'(DEPTH)});
      repeat (F - DEPTH) tick();
      check("t6_pre_boundary", {fsync_o, 31'(fifo_level)}, {1'b0, 31'(DEPTH)});
      y_in = 16'hDEAD;
      y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      check("t6_refused", {overflow, fsync_o, 30'(fifo_level)}, {2'b11, 30'(DEPTH - 1)});
      wait_idle(DEPTH * F * 2 + 200);
      check("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pcm_serial_tx.md
# pcm_serial_tx

Serializing transmitter for the filtered audio stream. It accepts 16-bit filter output samples over a valid/ready port and buffers them in a small FIFO. It then shifts each sample out MSB-first on a serial data line, with a generated bit clock and a frame-sync pulse. It sits downstream of the FIR filter core and replaces file-dump capture of `y` with a hardware serial link to the DAC/logger.

## Interface
- `DATA_W`, 16, sample width in bits
- `DEPTH`, 8, FIFO depth in words; power of 2, ≥2
- `CLK_DIV`, 4, `clk` cycles per serial bit; even, ≥2
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `y_in`  in  DATA_W  sample from filter (two's complement, transmitted as raw bits)
- `y_valid`  in  1  `y_in` valid this cycle
- `y_ready`  out  1  FIFO can accept; = !full, combinational from count
- `sclk_o`  out  1  serial bit clock, registered
- `sdata_o`  out  1  serial data, registered
- `fsync_o`  out  1  high during first bit period of every frame, registered
- `busy`  out  1  frame in progress
- `overflow`  out  1  sticky: valid asserted while full
- `fifo_level`  out  $clog2(DEPTH)+1  words stored

## Operation
- Push on `y_valid & y_ready`; sample at `y_valid & !y_ready` is dropped and sets `overflow`, held until `rst`.
- FSM states: IDLE, SHIFT.
  - IDLE: if FIFO not empty, pop head into shift register, zero bit/divider counters, go to SHIFT.
  - SHIFT: each bit held CLK_DIV cycles; `sclk_o` low for first CLK_DIV/2 cycles, high for the rest, so the receiver samples on the rising edge mid-bit.
  - After last bit: if FIFO non-empty, pop and restart immediately with no gap cycles; else IDLE.
- `fsync_o` = 1 exactly during bit 0 (MSB) period of each frame.
- In IDLE: `sclk_o`=0, `sdata_o`=0, `fsync_o`=0, `busy`=0.
- Push and pop in the same cycle: level unchanged. When full, push is refused even if a pop occurs that cycle, because `y_ready` uses the pre-pop count.
- Pointers wrap modulo DEPTH. `fifo_level` counts 0..DEPTH.
- Reset values: all outputs 0 except `y_ready`=1. FIFO is empty and the FSM is in IDLE.
- `rst` mid-frame aborts the frame and flushes the FIFO. Outputs are at reset values after the next edge.

## Timing
- Sample accepted at edge k into an empty FIFO with the FSM in IDLE: pop at edge k+1. MSB and `fsync_o` are visible after edge k+1.
- Frame length = DATA_W×CLK_DIV cycles (+CLK_DIV with parity). With defaults, 64 cycles.
- Sustained throughput is one sample per frame. A continuous 1-per-cycle input overflows after DEPTH+1 accepts.

## Configuration
- `PCM_TX_PARITY_EN` defined: one extra even-parity bit (XOR of all data bits) is sent after the LSB. Frame = DATA_W+1 bits. `fsync_o` is unchanged.
- Undefined: frame = DATA_W bits and there is no parity logic.

## Structure
- Package `pcm_tx_pkg`: FSM state enum (`ST_IDLE`, `ST_SHIFT`), default width/depth/divider constants, and a parity helper function.
- Sub-module `pcm_tx_fifo`: synchronous single-clock FIFO with push/pop, full/empty and level outputs. The top level holds the FSM, divider, bit counter and shift register.

## Test plan
- Single word 0xA5C3, defaults: `fsync_o` high cycles 1–4, `sdata_o` = 1010010111000011 with each bit 4 cycles. `busy` drops after cycle 64, and `sclk_o` shows 16 rising edges.
- Back-to-back 0x0001 then 0x8000: second `fsync_o` pulse begins exactly 64 cycles after the first. No idle cycle between frames, and the LSB of the first frame is 1.
- Burst of 10 words, one per cycle from empty: words 0–8 are accepted, with word 0 popped at edge 1. `fifo_level`=8, `y_ready`=0, word 9 dropped, `overflow`=1. Frames carry words 0–8 in order.
- `rst` asserted during bit 5 of 0xFFFF with 3 words queued: after the next edge outputs are 0, `fifo_level`=0, `overflow`=0, `y_ready`=1. No further frames follow.
- `PCM_TX_PARITY_EN` with 0x0007: 17-bit frame, last bit 1. With 0x0003, last bit 0; frame = 68 cycles.
- Push while full with a simultaneous pop at a frame boundary: push refused, `overflow` set, level goes DEPTH→DEPTH-1.
